// File: rtl/led_cube_stream_pkg.sv
// rtl/led_cube_stream_pkg.sv - frame geometry, derived widths and loader state type
package led_cube_stream_pkg;

    localparam int FRAME_BYTES = 64;
    localparam int NUM_FRAMES  = 8;
    localparam int BYTE_W      = $clog2(FRAME_BYTES);
    localparam int SLOT_W      = $clog2(NUM_FRAMES);
    localparam int ADDR_W      = $clog2(FRAME_BYTES * NUM_FRAMES);
    localparam int COUNT_W     = $clog2(NUM_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMMIT
    } loader_state_t;

endpackage

// File: rtl/led_cube_stream_loader_if.sv
// rtl/led_cube_stream_loader_if.sv - byte stream, head-frame read and ring status bundle
interface led_cube_stream_loader_if;
    import led_cube_stream_pkg::*;

    logic               in_valid;
    logic               in_sof;
    logic [7:0]         in_data;
    logic               in_ready;
    logic [BYTE_W-1:0]  rd_addr;
    logic [7:0]         rd_data;
    logic               frame_avail;
    logic [SLOT_W-1:0]  rd_slot;
    logic               frame_release;
    logic [COUNT_W-1:0] frame_count;
    logic               sync_err;
    logic               release_err;

    modport master (
        output in_valid, in_sof, in_data, rd_addr, frame_release,
        input  in_ready, rd_data, frame_avail, rd_slot, frame_count, sync_err, release_err
    );

    modport slave (
        input  in_valid, in_sof, in_data, rd_addr, frame_release,
        output in_ready, rd_data, frame_avail, rd_slot, frame_count, sync_err, release_err
    );

endinterface

// File: rtl/led_cube_frame_ram.sv
// rtl/led_cube_frame_ram.sv - simple dual-port frame ring storage, sync write, registered read
module led_cube_frame_ram
    import led_cube_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [0:(1 << ADDR_W) - 1];

    // Only the output register is reset; array contents are left alone for block RAM mapping.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[raddr];
        end
    end

endmodule

// File: rtl/led_cube_stream_loader.sv
// rtl/led_cube_stream_loader.sv - assembles stream bytes into frames and commits them to the ring
module led_cube_stream_loader
    import led_cube_stream_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    led_cube_stream_loader_if.slave  bus
);

    localparam int                 TIMER_W    = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BYTE_TIMEOUT - 1);
    localparam logic [BYTE_W-1:0]  BYTE_LAST  = BYTE_W'(FRAME_BYTES - 1);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(NUM_FRAMES);

    loader_state_t      state;
    logic [SLOT_W-1:0]  wr_ptr;
    logic [SLOT_W-1:0]  rd_ptr;
    logic [BYTE_W-1:0]  byte_cnt;
    logic [TIMER_W-1:0] timer;
    logic [COUNT_W-1:0] frame_count;
    logic               sync_err;
    logic               release_err;

    logic               xfer;
    logic               ram_we;
    logic [BYTE_W-1:0]  wr_byte;
    logic               commit;
    logic               release_ok;

    assign bus.in_ready = !rst && (state != COMMIT) && (frame_count < FULL_COUNT);
    assign xfer         = bus.in_valid && bus.in_ready;
    assign ram_we       = xfer && ((state == FILL) || bus.in_sof);
    assign wr_byte      = bus.in_sof ? '0 : byte_cnt;
    assign commit       = (state == COMMIT);
    assign release_ok   = bus.frame_release && (frame_count != '0);

    assign bus.frame_count = frame_count;
    assign bus.frame_avail = (frame_count != '0);
    assign bus.rd_slot     = rd_ptr;
    assign bus.sync_err    = sync_err;
    assign bus.release_err = release_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            byte_cnt    <= '0;
            timer       <= '0;
            frame_count <= '0;
            sync_err    <= 1'b0;
            release_err <= 1'b0;
        end else begin
            sync_err    <= 1'b0;
            release_err <= bus.frame_release && (frame_count == '0);

            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (bus.in_sof) begin
                            byte_cnt <= BYTE_W'(1);
                            timer    <= '0;
                            state    <= FILL;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (xfer) begin
                        timer <= '0;
                        if (bus.in_sof) begin
                            // Early SOF: resynchronise onto the new frame in the same slot.
                            sync_err <= 1'b1;
                            byte_cnt <= BYTE_W'(1);
                        end else begin
                            byte_cnt <= byte_cnt + BYTE_W'(1);
                            if (byte_cnt == BYTE_LAST) begin
                                state <= COMMIT;
                            end
                        end
                    end else if (timer == TIMER_LAST) begin
                        sync_err <= 1'b1;
                        timer    <= '0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                COMMIT: begin
                    wr_ptr   <= wr_ptr + SLOT_W'(1);
                    byte_cnt <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (release_ok) begin
                rd_ptr <= rd_ptr + SLOT_W'(1);
            end

            case ({commit, release_ok})
                2'b10:   frame_count <= frame_count + COUNT_W'(1);
                2'b01:   frame_count <= frame_count - COUNT_W'(1);
                default: frame_count <= frame_count;
            endcase
        end
    end

    led_cube_frame_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (ram_we),
        .waddr   ({wr_ptr, wr_byte}),
        .wdata   (bus.in_data),
        .raddr   ({rd_ptr, bus.rd_addr}),
        .rd_data (bus.rd_data)
    );

endmodule

// File: tb/tb_led_cube_stream_loader.sv
// tb/tb_led_cube_stream_loader.sv - randomized scoreboard bench for the stream loader
module tb_led_cube_stream_loader;
    import led_cube_stream_pkg::*;

    localparam int TO = 200;

    typedef logic [7:0] frame_t [FRAME_BYTES];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_cube_stream_loader_if bus ();

    led_cube_stream_loader #(.BYTE_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    frame_t     ring_q[$];
    frame_t     cur;
    int         cur_len   = 0;
    bit         in_frame  = 0;
    int         head_slot = 0;
    int         sync_exp_q[$];
    int         rel_exp_q[$];
    logic [7:0] rd_exp_q[$];
    int         n_checks  = 0;
    int         n_pass    = 0;
    logic       rd_req    = 1'b0;
    logic       rd_req_d  = 1'b0;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic summary_and_finish();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic abort_run(string why);
        n_checks++;
        $display("FAIL %s: bound expired, got no response expected one", why);
        summary_and_finish();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents data or a pulse.
    always @(posedge clk) rd_req_d <= rd_req;

    always @(negedge clk) begin
        if (rd_req_d && rd_exp_q.size() > 0) begin
            logic [7:0] e;
            e = rd_exp_q.pop_front();
            chk("rd_data", int'(bus.rd_data), int'(e));
        end
        if (bus.sync_err === 1'b1) begin
            chk("sync_err_expected", int'(sync_exp_q.size() > 0), 1);
            if (sync_exp_q.size() > 0) void'(sync_exp_q.pop_front());
        end
        if (bus.release_err === 1'b1) begin
            chk("release_err_expected", int'(rel_exp_q.size() > 0), 1);
            if (rel_exp_q.size() > 0) void'(rel_exp_q.pop_front());
        end
    end

    task automatic model_byte(bit sof, logic [7:0] d);
        if (sof) begin
            if (in_frame) sync_exp_q.push_back(1);
            cur[0]   = d;
            cur_len  = 1;
            in_frame = 1;
        end else if (!in_frame) begin
            sync_exp_q.push_back(1);
        end else begin
            cur[cur_len] = d;
            cur_len++;
            if (cur_len == FRAME_BYTES) begin
                ring_q.push_back(cur);
                in_frame = 0;
            end
        end
    endtask

    task automatic send_byte(bit sof, logic [7:0] d);
        int w = 0;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_data  = d;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            w++;
            if (w > 2000) abort_run("in_ready_wait");
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        model_byte(sof, d);
    endtask

    task automatic send_frame(input frame_t f);
        send_byte(1'b1, f[0]);
        for (int i = 1; i < FRAME_BYTES; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_byte(1'b0, f[i]);
        end
    endtask

    task automatic rand_frame(output frame_t f);
        for (int i = 0; i < FRAME_BYTES; i++) f[i] = 8'($urandom);
    endtask

    task automatic do_release();
        bus.frame_release = 1'b1;
        if (ring_q.size() > 0) begin
            void'(ring_q.pop_front());
            head_slot = (head_slot + 1) % NUM_FRAMES;
        end else begin
            rel_exp_q.push_back(1);
        end
        tick();
        bus.frame_release = 1'b0;
    endtask

    task automatic read_head(int addr);
        frame_t f;
        f = ring_q[0];
        bus.rd_addr = BYTE_W'(addr);
        rd_req = 1'b1;
        rd_exp_q.push_back(f[addr]);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic read_random(int n);
        for (int i = 0; i < n; i++) read_head(int'($urandom_range(0, FRAME_BYTES - 1)));
        tick();
    endtask

    task automatic check_status(string tag);
        chk({tag, "_frame_count"}, int'(bus.frame_count), ring_q.size());
        chk({tag, "_frame_avail"}, int'(bus.frame_avail), int'(ring_q.size() != 0));
        chk({tag, "_rd_slot"}, int'(bus.rd_slot), head_slot);
        chk({tag, "_in_ready"}, int'(bus.in_ready), int'(ring_q.size() < NUM_FRAMES));
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
        chk({tag, "_rd_data"}, int'(bus.rd_data), 0);
        chk({tag, "_frame_avail"}, int'(bus.frame_avail), 0);
        chk({tag, "_rd_slot"}, int'(bus.rd_slot), 0);
        chk({tag, "_frame_count"}, int'(bus.frame_count), 0);
        chk({tag, "_sync_err"}, int'(bus.sync_err), 0);
        chk({tag, "_release_err"}, int'(bus.release_err), 0);
    endtask

    initial begin
        #2_000_000;
        abort_run("watchdog");
    end

    initial begin
        frame_t f;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.in_data = '0;
        bus.rd_addr = '0;
        bus.frame_release = 1'b0;
        tick();
        tick();
        check_reset_outputs("por");
        rst = 1'b0;
        tick();

        // Counting-pattern frame, commit latency and a known address.
        for (int i = 0; i < FRAME_BYTES; i++) f[i] = 8'(i);
        send_frame(f);
        chk("commit_cycle_in_ready", int'(bus.in_ready), 0);
        chk("commit_cycle_count", int'(bus.frame_count), 0);
        tick();
        check_status("first_frame");
        read_head(8'h25);
        read_random(6);
        do_release();
        tick();

        // Fill the ring to full, then free one slot.
        for (int n = 0; n < NUM_FRAMES; n++) begin
            rand_frame(f);
            send_frame(f);
        end
        tick();
        tick();
        check_status("full");
        read_random(4);
        do_release();
        tick();
        check_status("full_minus_one");
        while (ring_q.size() > 0) begin
            read_random(3);
            do_release();
        end
        tick();
        check_status("drained");

        // Aborted frame by early SOF, replaced by a 0xA5 frame.
        send_byte(1'b1, 8'($urandom));
        for (int i = 1; i < 20; i++) send_byte(1'b0, 8'($urandom));
        for (int i = 0; i < FRAME_BYTES; i++) f[i] = 8'hA5;
        send_frame(f);
        tick();
        tick();
        check_status("resync");
        chk("resync_sync_err_drained", sync_exp_q.size(), 0);
        for (int i = 0; i < FRAME_BYTES; i++) read_head(i);
        tick();
        do_release();
        tick();

        // Inter-byte timeout, then a stray non-SOF byte in IDLE.
        send_byte(1'b1, 8'($urandom));
        for (int i = 1; i < 10; i++) send_byte(1'b0, 8'($urandom));
        sync_exp_q.push_back(1);
        in_frame = 0;
        repeat (TO - 10) tick();
        chk("timeout_not_early", sync_exp_q.size(), 1);
        repeat (20) tick();
        chk("timeout_fired", sync_exp_q.size(), 0);
        check_status("after_timeout");
        send_byte(1'b0, 8'h5A);
        tick();
        tick();
        chk("stray_byte_sync_err", sync_exp_q.size(), 0);
        check_status("after_stray");

        // Release on the commit cycle keeps the count; then release on empty.
        for (int n = 0; n < 3; n++) begin
            rand_frame(f);
            send_frame(f);
        end
        tick();
        tick();
        check_status("three_frames");
        rand_frame(f);
        send_frame(f);
        do_release();
        tick();
        check_status("commit_and_release");
        while (ring_q.size() > 0) begin
            read_random(4);
            do_release();
        end
        tick();
        do_release();
        tick();
        tick();
        chk("release_err_seen", rel_exp_q.size(), 0);
        check_status("empty_release");

        // Reset in the middle of a frame.
        for (int n = 0; n < 2; n++) begin
            rand_frame(f);
            send_frame(f);
        end
        send_byte(1'b1, 8'($urandom));
        for (int i = 1; i < 40; i++) send_byte(1'b0, 8'($urandom));
        rst = 1'b1;
        tick();
        ring_q.delete();
        in_frame = 0;
        head_slot = 0;
        check_reset_outputs("mid_frame_rst");
        rst = 1'b0;
        tick();
        rand_frame(f);
        send_frame(f);
        tick();
        tick();
        check_status("after_rst");
        read_random(8);
        do_release();
        tick();

        // Random mix of frames, stray bytes and releases.
        for (int it = 0; it < 6; it++) begin
            case ($urandom_range(0, 2))
                0: begin rand_frame(f); send_frame(f); end
                1: send_byte(1'b0, 8'($urandom));
                default: if (ring_q.size() > 0) begin read_random(2); do_release(); end
            endcase
            tick();
            tick();
            check_status("random_mix");
        end

        repeat (3) tick();
        chk("sync_err_pending", sync_exp_q.size(), 0);
        chk("release_err_pending", rel_exp_q.size(), 0);
        chk("rd_pending", rd_exp_q.size(), 0);
        summary_and_finish();
    end

endmodule
